// File: rtl/register_file.sv
// Architectural register file: R0..R(NREGS-2) are storage, the top address aliases the PC+8 input.
// Two combinational read ports, one synchronous write port, optional same-cycle write forwarding.
module register_file #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RegWrite,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  input  logic [AW-1:0]    WA3,
  input  logic [WIDTH-1:0] WD3,
  input  logic [WIDTH-1:0] R15,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  localparam logic [AW-1:0] PcAddr = AW'(NREGS - 1);

  logic [WIDTH-1:0] regs_q [NREGS-1];
  logic             wr_en;
  logic             byp1;
  logic             byp2;
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;

  // Writes to the PC alias are dropped; the PC lives outside this block.
  always_comb begin
    wr_en = reset_n && RegWrite && (WA3 != PcAddr);
    byp1  = (BYPASS != 0) && wr_en && (RA1 == WA3);
    byp2  = (BYPASS != 0) && wr_en && (RA2 == WA3);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NREGS) - 1; i++) begin
      if (!reset_n) begin
        regs_q[i] <= '0;
      end else if (wr_en && (WA3 == AW'(i))) begin
        regs_q[i] <= WD3;
      end
    end
  end

  // Decoded mux: an unknown address selects nothing and never touches storage.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < int'(NREGS) - 1; i++) begin
      if (RA1 == AW'(i)) stored1 = regs_q[i];
      if (RA2 == AW'(i)) stored2 = regs_q[i];
    end
  end

  always_comb begin
    RD1 = stored1;
    RD2 = stored2;
    if (RA1 == PcAddr)  RD1 = R15;
    else if (!reset_n)  RD1 = '0;
    else if (byp1)      RD1 = WD3;
    if (RA2 == PcAddr)  RD2 = R15;
    else if (!reset_n)  RD2 = '0;
    else if (byp2)      RD2 = WD3;
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a forwarding and a non-forwarding instance share one stimulus stream
// and are checked against an array model of the register semantics.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_write;
  logic [3:0]  ra1, ra2, wa3;
  logic [31:0] wd3, r15;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [15];

  always #5 clk = ~clk;

  register_file #(.WIDTH(32), .NREGS(16), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset_n(reset_n), .RegWrite(reg_write), .RA1(ra1), .RA2(ra2), .WA3(wa3),
    .WD3(wd3), .R15(r15), .RD1(rd1_b), .RD2(rd2_b)
  );

  register_file #(.WIDTH(32), .NREGS(16), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .reset_n(reset_n), .RegWrite(reg_write), .RA1(ra1), .RA2(ra2), .WA3(wa3),
    .WD3(wd3), .R15(r15), .RD1(rd1_n), .RD2(rd2_n)
  );

  // Expected read value under the architectural rules for the current inputs.
  function automatic logic [31:0] exp_rd(input logic [3:0] ra, input bit byp);
    if (ra == 4'd15) return r15;
    if (!reset_n) return 32'h0;
    if (byp && reg_write && wa3 != 4'd15 && wa3 == ra) return wd3;
    return m_regs[ra];
  endfunction

  // Advance one clock edge, commit the edge to the model, then step off the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
    end else if (reg_write === 1'b1 && wa3 != 4'd15) begin
      m_regs[wa3] = wd3;
    end
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_write = 1'b1; wa3 = a; wd3 = d;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 15; n++) wr(4'(n), 32'hA5A5_0000 + n);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    r15 = 32'h0000_0108;
    for (int n = 0; n < 16; n++) begin
      logic [31:0] want;
      ra1 = 4'(n); ra2 = 4'(15 - n);
      #2;
      want = (n == 15) ? 32'h0000_0108 : 32'h0;
      checks++;
      if (rd1_b !== want || rd1_n !== want) begin
        errors++;
        $display("FAIL reset_rd1[%0d]: got %h/%h expected %h", n, rd1_b, rd1_n, want);
      end
      want = (n == 0) ? 32'h0000_0108 : 32'h0;
      checks++;
      if (rd2_b !== want || rd2_n !== want) begin
        errors++;
        $display("FAIL reset_rd2[%0d]: got %h/%h expected %h", 15 - n, rd2_b, rd2_n, want);
      end
    end
  endtask

  task automatic test_write_read();
    wr(4'd3, 32'h1234_5678);
    ra1 = 4'd3; ra2 = 4'd3;
    #2;
    checks++;
    if (rd1_b !== 32'h1234_5678 || rd2_b !== 32'h1234_5678 ||
        rd1_n !== 32'h1234_5678 || rd2_n !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_read_r3: got %h %h %h %h expected 12345678", rd1_b, rd2_b, rd1_n, rd2_n);
    end
    for (int n = 0; n < 15; n++) begin
      if (n == 3) continue;
      ra1 = 4'(n);
      #1;
      checks++;
      if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
        errors++;
        $display("FAIL write_read_other[%0d]: got %h/%h expected 0", n, rd1_b, rd1_n);
      end
    end
  endtask

  task automatic test_bypass();
    reg_write = 1'b1; wa3 = 4'd7; wd3 = 32'hDEAD_BEEF; ra1 = 4'd7; ra2 = 4'd7;
    #2;
    checks++;
    if (rd1_b !== 32'hDEAD_BEEF || rd2_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_fwd: got %h %h expected deadbeef", rd1_b, rd2_b);
    end
    checks++;
    if (rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL bypass_off_pre: got %h expected 0", rd1_n);
    end
    tick();
    reg_write = 1'b0;
    #1;
    checks++;
    if (rd1_n !== 32'hDEAD_BEEF || rd1_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_post: got %h/%h expected deadbeef", rd1_b, rd1_n);
    end
  endtask

  task automatic test_r15_alias();
    logic [31:0] snap [15];
    for (int i = 0; i < 15; i++) snap[i] = m_regs[i];
    r15 = 32'h0000_0020;
    reg_write = 1'b1; wa3 = 4'd15; wd3 = 32'hFFFF_FFFF; ra1 = 4'd15; ra2 = 4'd15;
    #2;
    checks++;
    if (rd1_b !== 32'h20 || rd2_b !== 32'h20 || rd2_n !== 32'h20) begin
      errors++;
      $display("FAIL r15_no_bypass: got %h %h %h expected 00000020", rd1_b, rd2_b, rd2_n);
    end
    tick();
    reg_write = 1'b0;
    #1;
    checks++;
    if (rd2_b !== 32'h20 || rd2_n !== 32'h20) begin
      errors++;
      $display("FAIL r15_after: got %h/%h expected 00000020", rd2_b, rd2_n);
    end
    for (int n = 0; n < 15; n++) begin
      ra2 = 4'(n);
      #1;
      checks++;
      if (rd2_b !== snap[n] || rd2_n !== snap[n]) begin
        errors++;
        $display("FAIL r15_unchanged[%0d]: got %h/%h expected %h", n, rd2_b, rd2_n, snap[n]);
      end
    end
  endtask

  task automatic test_reset_vs_write();
    wr(4'd4, 32'h0000_0AAA);
    reset_n = 1'b0; reg_write = 1'b1; wa3 = 4'd4; wd3 = 32'h0000_0055; ra1 = 4'd4; ra2 = 4'd4;
    #2;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL rst_vs_wr_during: got %h/%h expected 0", rd1_b, rd1_n);
    end
    tick();
    reset_n = 1'b1; reg_write = 1'b0;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL rst_vs_wr_after: got %h/%h expected 0", rd1_b, rd1_n);
    end
  endtask

  task automatic test_alu_hookup();
    logic [31:0] alu_result;
    wr(4'd0, 32'h0000_0077);
    wr(4'd1, 32'd5);
    wr(4'd2, 32'd5);
    ra1 = 4'd1; ra2 = 4'd2;
    #2;
    alu_result = rd1_b - rd2_b;
    checks++;
    if (rd1_b !== 32'd5 || rd2_b !== 32'd5 || alu_result !== 32'h0) begin
      errors++;
      $display("FAIL alu_operands: got %h %h result %h expected 5 5 result 0", rd1_b, rd2_b,
               alu_result);
    end
    wr(4'd0, alu_result);
    ra1 = 4'd0;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL alu_writeback_r0: got %h/%h expected 0", rd1_b, rd1_n);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    ra1 = 4'd9; ra2 = 4'd9;
    for (int k = 0; k < 3; k++) begin
      reg_write = 1'b1; wa3 = 4'd9; wd3 = 32'h0B0B_0000 + k;
      #2;
      e = exp_rd(4'd9, 1'b1);
      checks++;
      if (rd1_b !== e || rd2_b !== e) begin
        errors++;
        $display("FAIL b2b_byp[%0d]: got %h %h expected %h", k, rd1_b, rd2_b, e);
      end
      e = exp_rd(4'd9, 1'b0);
      checks++;
      if (rd1_n !== e) begin
        errors++;
        $display("FAIL b2b_nobyp[%0d]: got %h expected %h", k, rd1_n, e);
      end
      tick();
    end
    reg_write = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int it = 0; it < 400; it++) begin
      reset_n   = ($urandom_range(0, 15) != 0);
      reg_write = 1'($urandom_range(0, 1));
      ra1 = 4'($urandom); ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 4'($urandom);
      wa3 = ($urandom_range(0, 2) == 0) ? ra1 : 4'($urandom);
      wd3 = $urandom; r15 = $urandom;
      #2;
      e = exp_rd(ra1, 1'b1);
      checks++;
      if (rd1_b !== e) begin
        errors++;
        $display("FAIL rand_rd1_byp[%0d]: ra=%0d got %h expected %h", it, ra1, rd1_b, e);
      end
      e = exp_rd(ra2, 1'b1);
      checks++;
      if (rd2_b !== e) begin
        errors++;
        $display("FAIL rand_rd2_byp[%0d]: ra=%0d got %h expected %h", it, ra2, rd2_b, e);
      end
      e = exp_rd(ra1, 1'b0);
      checks++;
      if (rd1_n !== e) begin
        errors++;
        $display("FAIL rand_rd1_nobyp[%0d]: ra=%0d got %h expected %h", it, ra1, rd1_n, e);
      end
      e = exp_rd(ra2, 1'b0);
      checks++;
      if (rd2_n !== e) begin
        errors++;
        $display("FAIL rand_rd2_nobyp[%0d]: ra=%0d got %h expected %h", it, ra2, rd2_n, e);
      end
      tick();
    end
    reset_n = 1'b1; reg_write = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; reg_write = 1'b0;
    ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0; r15 = '0;
    for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_r15_alias();
    test_reset_vs_write();
    test_alu_hookup();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
